// File: rtl/int_pc_redirect_pkg.sv
// Shared definitions for the interrupt/eret PC redirect unit and the control decoder.
package int_pc_redirect_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } state_e;

    localparam logic [31:0] VECTOR_DEFAULT = 32'h0000_0004;
    localparam logic [5:0]  OPC_ERET       = 6'b010000;

    function automatic logic is_eret_op(input logic [5:0] opcode);
        return opcode == OPC_ERET;
    endfunction

endpackage

// File: rtl/int_pc_redirect_int_sync.sv
// Synchroniser chain for the external interrupt plus a rising-edge detector
// producing a one-cycle rise pulse.
module int_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   prev_d;

    // prev_q holds 1 until the chain has refilled after reset, so a level that
    // was already high through reset is not mistaken for a new edge.
    assign prev_d = fill_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/int_pc_redirect.sv
// Interrupt entry / eret return PC redirect with EPC save and pending request.
// Optional interrupt mask input is enabled by defining INT_MASK_EN.
module int_pc_redirect
    import int_pc_redirect_pkg::*;
#(
    parameter logic [31:0] VECTOR      = VECTOR_DEFAULT,
    parameter logic [31:0] EPC_RST     = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        eret,
    input  logic        cpu_stall,
`ifdef INT_MASK_EN
    input  logic        int_mask,
`endif
    input  logic [31:0] pc_next,
    output logic [31:0] pc_out,
    output logic        int_code,
    output logic        int_ack,
    output logic [31:0] epc
);

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic [31:0] epc_q, epc_d;
    logic        int_rise;
    logic        mask;

`ifdef INT_MASK_EN
    assign mask = int_mask;
`else
    assign mask = 1'b0;
`endif

    int_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_int_sync (
        .clk    (clk),
        .rst    (rst),
        .async_i(INT),
        .rise_o (int_rise)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            epc_q     <= EPC_RST;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            epc_q     <= epc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | int_rise;
        epc_d     = epc_q;
        pc_out    = pc_next;
        int_ack   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q && !cpu_stall && !mask) begin
                    // An edge landing in the take cycle stays pending for later.
                    pc_out    = VECTOR;
                    epc_d     = pc_next;
                    pending_d = int_rise;
                    int_ack   = 1'b1;
                    state_d   = ST_ISR;
                end
            end
            ST_ISR: begin
                if (eret && !cpu_stall) begin
                    pc_out  = epc_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign int_code = (state_q == ST_ISR);
    assign epc      = epc_q;

endmodule
